// File: rtl/cond_pkg.sv
// Shared definitions for the condition-check block: condition codes, NZCV bit
// positions and the flags vector type.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE, CS, CC, MI, PL, VS, VC,
        HI, LS, GE, LT, GT, LE, AL, NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction's
// condition field holds against the stored NZCV flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] i_cond,
    input  flags_t     i_flags,
    output logic       o_cond_ex
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        o_cond_ex = 1'b0;
        case (cond_e'(i_cond))
            EQ: o_cond_ex = w_z;
            NE: o_cond_ex = ~w_z;
            CS: o_cond_ex = w_c;
            CC: o_cond_ex = ~w_c;
            MI: o_cond_ex = w_n;
            PL: o_cond_ex = ~w_n;
            VS: o_cond_ex = w_v;
            VC: o_cond_ex = ~w_v;
            HI: o_cond_ex = w_c & ~w_z;
            LS: o_cond_ex = ~w_c | w_z;
            GE: o_cond_ex = (w_n == w_v);
            LT: o_cond_ex = (w_n != w_v);
            GT: o_cond_ex = ~w_z & (w_n == w_v);
            LE: o_cond_ex = w_z | (w_n != w_v);
            AL: o_cond_ex = 1'b1;
            NV: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds the NZCV register and gates the decoder's
// write requests by the instruction condition. Optional stall via COND_STALL_EN.
module cond_logic
    import cond_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
`ifdef COND_STALL_EN
    input  logic       Stall,
`endif
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    flags_t r_flags;
    logic   w_cond_ex;
    logic   w_go;
    logic   w_upd_nz;
    logic   w_upd_cv;

    cond_check u_cond_check (
        .i_cond    (Cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    // A stalled instruction still reports its condition but commits nothing.
`ifdef COND_STALL_EN
    assign w_go = w_cond_ex & ~Stall;
`else
    assign w_go = w_cond_ex;
`endif

    assign w_upd_nz = FlagW[1] & w_go;
    assign w_upd_cv = FlagW[0] & w_go;

    assign CondEx   = w_cond_ex;
    assign PCSrc    = PCS  & w_go;
    assign MemWrite = MemW & w_go;
    assign RegWrite = RegW & w_go & ~NoWrite;
    assign Flags    = r_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_flags <= '0;
        end else begin
            if (w_upd_nz) r_flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            if (w_upd_cv) r_flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
        end
    end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios plus randomized
// stimulus checked against an NZCV reference model.
module tb_cond_logic;

    logic       clk;
    logic       rst_n;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite;
    logic       Stall;
    logic       PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] m_flags;

    cond_logic dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
`ifdef COND_STALL_EN
        .Stall    (Stall),
`endif
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit stall_active();
`ifdef COND_STALL_EN
        return Stall;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: pairs of conditions share a base test, odd codes invert it.
    function automatic bit exp_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    // Expected {PCSrc, RegWrite, MemWrite, CondEx} from current inputs and model.
    function automatic logic [3:0] exp_outs();
        bit ce, go;
        ce = exp_cond(Cond, m_flags);
        go = ce && !stall_active();
        return {PCS && go, RegW && go && !NoWrite, MemW && go, ce};
    endfunction

    task automatic tick();
        if (exp_cond(Cond, m_flags) && !stall_active()) begin
            if (FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
            if (FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
        tick();
        FlagW = 2'b00;
    endtask

    task automatic test_reset();
        logic [3:0] conds [4] = '{4'b0000, 4'b0001, 4'b1010, 4'b1110};
        logic       want  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        rst_n = 0; Cond = 0; ALUFlags = 4'hF; FlagW = 2'b11;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; Stall = 0;
        m_flags = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (Flags !== 4'h0) begin
            n_errors++; $display("FAIL reset_flags: got %b want 0000", Flags);
        end
        for (int i = 0; i < 4; i++) begin
            Cond = conds[i]; #1;
            n_checks++;
            if (CondEx !== want[i]) begin
                n_errors++; $display("FAIL reset_cond %b: got %b want %b", conds[i], CondEx, want[i]);
            end
        end
        FlagW = 2'b00; Cond = 0;
        #2 rst_n = 1;
        @(negedge clk);
        Cond = 4'b0000; #1;
        n_checks++;
        if (CondEx !== 1'b0 || Flags !== 4'h0) begin
            n_errors++; $display("FAIL post_reset_eq: got cex=%b flags=%b want 0 0000", CondEx, Flags);
        end
        Cond = 4'b0001; #1;
        n_checks++;
        if (CondEx !== 1'b1) begin
            n_errors++; $display("FAIL post_reset_ne: got %b want 1", CondEx);
        end
    endtask

    task automatic test_failed_cond();
        Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'hF;
        PCS = 1; RegW = 1; MemW = 1; NoWrite = 0; #1;
        n_checks++;
        if ({PCSrc, RegWrite, MemWrite, CondEx} !== 4'b0000) begin
            n_errors++; $display("FAIL failed_cond_en: got %b want 0000", {PCSrc, RegWrite, MemWrite, CondEx});
        end
        tick();
        n_checks++;
        if (Flags !== 4'h0 || Flags !== m_flags) begin
            n_errors++; $display("FAIL failed_cond_flags: got %b want 0000", Flags);
        end
        PCS = 0; RegW = 0; MemW = 0; FlagW = 2'b00;
    endtask

    task automatic test_latency();
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100; #1;
        Cond = 4'b0000; #1;
        n_checks++;
        if (CondEx !== 1'b0) begin
            n_errors++; $display("FAIL latency_same_cycle: got %b want 0", CondEx);
        end
        Cond = 4'b1110; #1;
        tick();
        Cond = 4'b0000; FlagW = 2'b00; #1;
        n_checks++;
        if (Flags !== 4'b0100 || CondEx !== 1'b1) begin
            n_errors++; $display("FAIL latency_next_cycle: got flags=%b cex=%b want 0100 1", Flags, CondEx);
        end
    endtask

    task automatic test_partial();
        set_flags(4'b0111);
        Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1011;
        tick();
        n_checks++;
        if (Flags !== 4'b1011) begin
            n_errors++; $display("FAIL partial_nz: got %b want 1011", Flags);
        end
        FlagW = 2'b01; ALUFlags = 4'b0000;
        tick();
        n_checks++;
        if (Flags !== 4'b1000) begin
            n_errors++; $display("FAIL partial_cv: got %b want 1000", Flags);
        end
        FlagW = 2'b00; ALUFlags = 4'hF;
        tick();
        n_checks++;
        if (Flags !== 4'b1000) begin
            n_errors++; $display("FAIL flagw_00_ignores_alu: got %b want 1000", Flags);
        end
    endtask

    task automatic test_sweep();
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            n_checks++;
            if (Flags !== 4'(f)) begin
                n_errors++; $display("FAIL sweep_load %0d: got %b", f, Flags);
            end
            PCS = 1; RegW = 1; MemW = 1; NoWrite = 1;
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c); #1;
                n_checks++;
                if ({PCSrc, RegWrite, MemWrite, CondEx} !== exp_outs()) begin
                    n_errors++;
                    $display("FAIL sweep cond=%b flags=%b: got %b want %b",
                             4'(c), 4'(f), {PCSrc, RegWrite, MemWrite, CondEx}, exp_outs());
                end
            end
            NoWrite = 0;
        end
        PCS = 0; RegW = 0; MemW = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            Cond = 4'($urandom); ALUFlags = 4'($urandom); FlagW = 2'($urandom);
            PCS = 1'($urandom); RegW = 1'($urandom); MemW = 1'($urandom);
            NoWrite = 1'($urandom);
`ifdef COND_STALL_EN
            Stall = ($urandom_range(0, 3) == 0);
`endif
            #1;
            n_checks++;
            if ({PCSrc, RegWrite, MemWrite, CondEx} !== exp_outs()) begin
                n_errors++;
                $display("FAIL random_outs %0d: got %b want %b", i, {PCSrc, RegWrite, MemWrite, CondEx}, exp_outs());
            end
            tick();
            n_checks++;
            if (Flags !== m_flags) begin
                n_errors++; $display("FAIL random_flags %0d: got %b want %b", i, Flags, m_flags);
            end
        end
        Stall = 0; FlagW = 2'b00;
    endtask

    task automatic test_async_reset();
        set_flags(4'b1111);
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1010;
        #2 rst_n = 0;
        m_flags = 4'h0;
        #1;
        n_checks++;
        if (Flags !== 4'h0) begin
            n_errors++; $display("FAIL async_reset: got %b want 0000", Flags);
        end
        @(posedge clk); #1;
        n_checks++;
        if (Flags !== 4'h0) begin
            n_errors++; $display("FAIL reset_holds_over_edge: got %b want 0000", Flags);
        end
        FlagW = 2'b00;
        #2 rst_n = 1;
        tick();
        n_checks++;
        if (Flags !== 4'h0) begin
            n_errors++; $display("FAIL no_pending_write: got %b want 0000", Flags);
        end
    endtask

`ifdef COND_STALL_EN
    task automatic test_stall();
        set_flags(4'b0101);
        Stall = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1010;
        PCS = 1; RegW = 1; MemW = 1; NoWrite = 0; #1;
        n_checks++;
        if ({PCSrc, RegWrite, MemWrite, CondEx} !== 4'b0001) begin
            n_errors++; $display("FAIL stall_en: got %b want 0001", {PCSrc, RegWrite, MemWrite, CondEx});
        end
        tick();
        n_checks++;
        if (Flags !== 4'b0101) begin
            n_errors++; $display("FAIL stall_flags: got %b want 0101", Flags);
        end
        Stall = 0; PCS = 0; RegW = 0; MemW = 0; FlagW = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_failed_cond();
        test_latency();
        test_partial();
        test_sweep();
        test_random();
        test_async_reset();
`ifdef COND_STALL_EN
        test_stall();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
